// File: rtl/marie_core_p.sv
// marie_core_p: parametrised MARIE accumulator core with a CS/OE/vld fetch handshake.
// Optional fetch watchdog is compiled in with `define MARIE_TIMEOUT_EN.
module marie_core_p #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+7:0] mdata,
    input  logic              vld,
    input  logic [DATA_W-1:0] PA,
    output logic [ADDR_W-1:0] PC,
    output logic              CS,
    output logic              OE,
    output logic [DATA_W-1:0] PB,
    output logic              zf,
    output logic              halted,
    output logic              err
);

    typedef enum logic [1:0] {S_RST, S_FETCH, S_EXEC, S_HALT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        op;
    logic [DATA_W-1:0] lit;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] alu_res;
    logic              is_alu;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              timeout;

    // Jump target: literal truncated or zero-extended to the address width.
    if (ADDR_W <= DATA_W) begin : g_tgt_trunc
        assign jmp_tgt = lit[ADDR_W-1:0];
    end else begin : g_tgt_ext
        assign jmp_tgt = {{(ADDR_W-DATA_W){1'b0}}, lit};
    end

`ifdef MARIE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;
    logic             err_q;

    // Counter is held at zero outside FETCH, so every FETCH entry starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (state != S_FETCH) begin
            cnt <= '0;
        end else if (!vld) begin
            cnt <= cnt + 1'b1;
            if (timeout) err_q <= 1'b1;
        end
    end

    assign timeout = (state == S_FETCH) && !vld && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign err     = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:   state_nxt = S_FETCH;
            S_FETCH: begin
                if (timeout)  state_nxt = S_HALT;
                else if (vld) state_nxt = S_EXEC;
            end
            S_EXEC:  state_nxt = (op == 8'h18) ? S_HALT : S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
    end

    always_comb begin
        alu_res = '0;
        is_alu  = (op[7:4] == 4'h0);
        case (op[3:0])
            4'h0: alu_res = a + b;
            4'h1: alu_res = a - b;
            4'h2: alu_res = a * b;
            4'h3: alu_res = (b == '0) ? '1 : a / b;
            4'h4: alu_res = a << 1;
            4'h5: alu_res = a >> 1;
            4'h6: alu_res = {a[DATA_W-2:0], a[DATA_W-1]};
            4'h7: alu_res = {a[0], a[DATA_W-1:1]};
            4'h8: alu_res = a & b;
            4'h9: alu_res = a | b;
            4'hA: alu_res = a ^ b;
            4'hB: alu_res = ~(a | b);
            4'hC: alu_res = ~(a & b);
            4'hD: alu_res = ~(a ^ b);
            4'hE: alu_res = {{(DATA_W-1){1'b0}}, (a > b)};
            4'hF: alu_res = {{(DATA_W-1){1'b0}}, (a == b)};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        pc_nxt = PC + 1'b1;
        case (op)
            8'h16:   pc_nxt = jmp_tgt;
            8'h17:   pc_nxt = zf ? jmp_tgt : PC + 1'b1;
            8'h18:   pc_nxt = PC;
            default: pc_nxt = PC + 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_RST;
            PC     <= '0;
            a      <= '0;
            b      <= '0;
            PB     <= '0;
            CS     <= 1'b0;
            OE     <= 1'b0;
            zf     <= 1'b0;
            halted <= 1'b0;
            op     <= '0;
            lit    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_RST: begin
                    CS <= 1'b1;
                    OE <= 1'b1;
                end
                S_FETCH: begin
                    if (timeout) begin
                        CS     <= 1'b0;
                        OE     <= 1'b0;
                        halted <= 1'b1;
                    end else if (vld) begin
                        op  <= mdata[7:0];
                        lit <= mdata[DATA_W+7:8];
                        CS  <= 1'b0;
                        OE  <= 1'b0;
                    end
                end
                S_EXEC: begin
                    PC <= pc_nxt;
                    if (is_alu) begin
                        a  <= alu_res;
                        zf <= (alu_res == '0);
                    end
                    case (op)
                        8'h10: PB <= a;
                        8'h11: a  <= PA;
                        8'h12: PB <= PA;
                        8'h13: b  <= lit;
                        8'h14: a  <= lit;
                        8'h15: begin
                            a <= b;
                            b <= a;
                        end
                        default: ;
                    endcase
                    if (op == 8'h18) begin
                        halted <= 1'b1;
                    end else begin
                        CS <= 1'b1;
                        OE <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_marie_core_p.sv
// Self-checking bench for marie_core_p: directed programs plus random programs
// checked against an instruction-level reference model of the ISA.
module tb_marie_core_p;

    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int MASK = (1 << DW) - 1;

    logic          clk;
    logic          rst;
    logic [DW+7:0] mdata;
    logic          vld;
    logic [DW-1:0] PA;
    logic [AW-1:0] PC;
    logic          CS;
    logic          OE;
    logic [DW-1:0] PB;
    logic          zf;
    logic          halted;
    logic          err;

    logic [15:0] prog [0:255];

    int total;
    int bad;

    // Reference model state (instruction level).
    int m_a, m_b, m_pc, m_pb, m_zf, m_halt;

    marie_core_p #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .mdata(mdata), .vld(vld), .PA(PA),
        .PC(PC), .CS(CS), .OE(OE), .PB(PB), .zf(zf), .halted(halted), .err(err)
    );

    assign mdata = prog[PC];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0019;
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_pc = 0; m_pb = 0; m_zf = 0; m_halt = 0;
    endtask

    task automatic model_step(input logic [15:0] ins, input int pa);
        int op, lit, r, nxt, t;
        bit alu;
        op  = int'(ins[7:0]);
        lit = int'(ins[15:8]);
        nxt = (m_pc + 1) % 256;
        alu = (op < 16);
        r   = 0;
        case (op)
            0:  r = (m_a + m_b) % 256;
            1:  r = (m_a - m_b + 256) % 256;
            2:  r = (m_a * m_b) % 256;
            3:  r = (m_b == 0) ? MASK : m_a / m_b;
            4:  r = (m_a * 2) % 256;
            5:  r = m_a / 2;
            6:  r = (m_a * 2) % 256 + m_a / 128;
            7:  r = m_a / 2 + (m_a % 2) * 128;
            8:  r = m_a & m_b;
            9:  r = m_a | m_b;
            10: r = m_a ^ m_b;
            11: r = ~(m_a | m_b) & MASK;
            12: r = ~(m_a & m_b) & MASK;
            13: r = ~(m_a ^ m_b) & MASK;
            14: r = (m_a > m_b) ? 1 : 0;
            15: r = (m_a == m_b) ? 1 : 0;
            16: m_pb = m_a;
            17: m_a = pa;
            18: m_pb = pa;
            19: m_b = lit;
            20: m_a = lit;
            21: begin t = m_a; m_a = m_b; m_b = t; end
            22: nxt = lit % 256;
            23: if (m_zf != 0) nxt = lit % 256;
            24: begin m_halt = 1; nxt = m_pc; end
            default: ;
        endcase
        if (alu) begin
            m_a  = r;
            m_zf = (r == 0) ? 1 : 0;
        end
        m_pc = nxt;
    endtask

    // Reset pulse, then leave the core at a falling edge in its first FETCH cycle.
    task automatic do_reset();
        rst = 1'b0;
        vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One instruction: optional stall in FETCH, then the EXEC cycle, then compare.
    task automatic step(input int stall);
        vld = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (CS !== 1'b1 || OE !== 1'b1 || PC !== AW'(m_pc)) begin
                bad++;
                $display("FAIL stall: CS=%b OE=%b PC=%h, need CS=1 OE=1 PC=%h", CS, OE, PC, m_pc[AW-1:0]);
            end
        end
        vld = 1'b1;
        model_step(prog[m_pc], int'(PA));
        @(posedge clk);
        @(negedge clk);
        total++;
        if (CS !== 1'b0 || OE !== 1'b0) begin
            bad++;
            $display("FAIL exec_cs: CS=%b OE=%b, need 0 0", CS, OE);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (PC !== AW'(m_pc) || PB !== DW'(m_pb) || zf !== m_zf[0] || halted !== m_halt[0]
            || CS !== !m_halt[0] || OE !== !m_halt[0]) begin
            bad++;
            $display("FAIL instr: PC=%h PB=%h zf=%b halted=%b CS=%b OE=%b, need PC=%h PB=%h zf=%0d halted=%0d CS=OE=%0d",
                     PC, PB, zf, halted, CS, OE, m_pc[AW-1:0], m_pb[DW-1:0], m_zf, m_halt, !m_halt[0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        vld = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({PC, PB, CS, OE, zf, halted, err} !== '0) begin
            bad++;
            $display("FAIL reset: PC=%h PB=%h CS=%b OE=%b zf=%b halted=%b err=%b, need all 0",
                     PC, PB, CS, OE, zf, halted, err);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (CS !== 1'b1 || OE !== 1'b1 || PC !== '0) begin
            bad++;
            $display("FAIL first_fetch: CS=%b OE=%b PC=%h, need 1 1 00", CS, OE, PC);
        end
    endtask

    task automatic test_basic();
        clear_prog();
        prog[0] = 16'h0514; prog[1] = 16'h0313; prog[2] = 16'h0000; prog[3] = 16'h0010;
        do_reset();
        for (int i = 0; i < 4; i++) step(0);
        total++;
        if (PB !== 8'h08 || PC !== 8'h04) begin
            bad++;
            $display("FAIL basic_add: PB=%h PC=%h, need PB=08 PC=04", PB, PC);
        end
    endtask

    task automatic test_jz();
        clear_prog();
        prog[0] = 16'h0014; prog[1] = 16'h0000; prog[2] = 16'h2017;
        do_reset();
        step(0); step(0);
        total++;
        if (zf !== 1'b1) begin
            bad++;
            $display("FAIL jz_zf1: zf=%b, need 1", zf);
        end
        step(0);
        total++;
        if (PC !== 8'h20) begin
            bad++;
            $display("FAIL jz_taken: PC=%h, need 20", PC);
        end
        prog[0] = 16'h0114;
        do_reset();
        step(0); step(0); step(0);
        total++;
        if (zf !== 1'b0 || PC !== 8'h03) begin
            bad++;
            $display("FAIL jz_not_taken: zf=%b PC=%h, need zf=0 PC=03", zf, PC);
        end
    endtask

    task automatic test_div_mul();
        clear_prog();
        prog[0] = 16'h4014; prog[1] = 16'h0013; prog[2] = 16'h0003; prog[3] = 16'h0010;
        prog[4] = 16'h1013; prog[5] = 16'h0002; prog[6] = 16'h0010;
        do_reset();
        for (int i = 0; i < 4; i++) step(0);
        total++;
        if (PB !== 8'hFF || zf !== 1'b0) begin
            bad++;
            $display("FAIL div_zero: PB=%h zf=%b, need PB=FF zf=0", PB, zf);
        end
        for (int i = 0; i < 3; i++) step(0);
        total++;
        if (PB !== 8'hF0) begin
            bad++;
            $display("FAIL mul_low: PB=%h, need F0", PB);
        end
    endtask

    task automatic test_ports_wrap();
        clear_prog();
        prog[0] = 16'h0011; prog[1] = 16'h0012; prog[2] = 16'h0010; prog[3] = 16'hFF16;
        PA = 8'hA5;
        do_reset();
        step(0); step(0);
        total++;
        if (PB !== 8'hA5) begin
            bad++;
            $display("FAIL pa_to_pb: PB=%h, need A5", PB);
        end
        PA = 8'h3C;
        step(0);
        total++;
        if (PB !== 8'hA5) begin
            bad++;
            $display("FAIL a_from_pa: PB=%h, need A5", PB);
        end
        step(0);
        step(0);
        total++;
        if (PC !== 8'h00) begin
            bad++;
            $display("FAIL pc_wrap: PC=%h, need 00", PC);
        end
    endtask

    task automatic test_stall_reset();
        clear_prog();
        prog[0] = 16'h5A14; prog[1] = 16'h0010; prog[2] = 16'h0000;
        do_reset();
        step(5);
        step(0);
        total++;
        if (PB !== 8'h5A) begin
            bad++;
            $display("FAIL stall_resume: PB=%h, need 5A", PB);
        end
        vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({PC, PB, CS, OE, zf, halted, err} !== '0) begin
            bad++;
            $display("FAIL async_reset: PC=%h PB=%h CS=%b OE=%b zf=%b halted=%b err=%b, need all 0",
                     PC, PB, CS, OE, zf, halted, err);
        end
    endtask

    task automatic test_halt();
        clear_prog();
        prog[0] = 16'h0514; prog[1] = 16'h0010; prog[2] = 16'h0018;
        do_reset();
        step(0); step(0); step(0);
        for (int i = 0; i < 4; i++) begin
            vld = i[0];
            @(posedge clk);
            @(negedge clk);
        end
        total++;
        if (halted !== 1'b1 || PC !== 8'h02 || CS !== 1'b0 || OE !== 1'b0 || err !== 1'b0 || PB !== 8'h05) begin
            bad++;
            $display("FAIL halt_hold: halted=%b PC=%h CS=%b OE=%b err=%b PB=%h, need 1 02 0 0 0 05",
                     halted, PC, CS, OE, err, PB);
        end
    endtask

`ifdef MARIE_TIMEOUT_EN
    task automatic test_timeout();
        clear_prog();
        do_reset();
        vld = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        total++;
        if (halted !== 1'b0 || err !== 1'b0 || CS !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early: halted=%b err=%b CS=%b, need 0 0 1", halted, err, CS);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (halted !== 1'b1 || err !== 1'b1 || CS !== 1'b0 || OE !== 1'b0) begin
            bad++;
            $display("FAIL timeout_fire: halted=%b err=%b CS=%b OE=%b, need 1 1 0 0", halted, err, CS, OE);
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] op;
        for (int i = 0; i < 256; i++) begin
            op = 8'($urandom_range(0, 31));
            if (op == 8'h18) op = 8'h15;
            prog[i] = {8'($urandom_range(0, 255)), op};
        end
        do_reset();
        for (int n = 0; n < 300; n++) begin
            PA = 8'($urandom_range(0, 255));
            step($urandom_range(0, 2));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        vld   = 1'b0;
        PA    = '0;
        clear_prog();
        test_reset();
        test_basic();
        test_jz();
        test_div_mul();
        test_ports_wrap();
        test_stall_reset();
        test_halt();
`ifdef MARIE_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
